fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  IF stage of the RV32I 5-stage pipeline: owns the fetch PC, drives the instruction-memory
//  request/response port, and holds the IF/ID pipeline register consumed by decode/hazard_detection.
//  Obeys pc_en/IF_ID_en stalls from hazard_detection and redirect/flush from EX branch resolution.
//  Absorbs one response returned during a stall in a 1-entry skid buffer; discards stale responses after redirect.
// PARAMETERS
//  RESET_PC   32'h0000_0000  first fetch address after reset
//  NOP_INST   32'h0000_0013  bubble encoding (addi x0,x0,0) loaded into IF/ID on flush/bubble
// PORTS
//  clk_i            in   1   clock, all state updates on rising edge
//  rst_i            in   1   synchronous, active-high reset
//  pc_en_i          in   1   from hazard_detection; 0 = no new fetch request, PC holds
//  IF_ID_en_i       in   1   from hazard_detection; 0 = IF/ID register holds
//  branch_taken_i   in   1   EX redirect; flushes IF/ID and fetch
//  branch_target_i  in   32  redirect address; bits [1:0] ignored (forced 0)
//  imem_req_o       out  1   fetch request valid
//  imem_addr_o      out  32  fetch address (= pc_q, word aligned)
//  imem_gnt_i       in   1   request accepted this cycle (req & gnt)
//  imem_rvalid_i    in   1   response valid, >=1 cycle after grant, max 1 outstanding
//  imem_rdata_i     in   32  fetched instruction
//  inst_ID_o        out  32  IF/ID instruction
//  pc_ID_o          out  32  IF/ID PC of inst_ID_o
//  valid_ID_o       out  1   IF/ID holds a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset: pc_q=RESET_PC; inst_ID_o=NOP_INST, pc_ID_o=0, valid_ID_o=0; imem_req_o=0; skid empty; state=REQ.
//  States: REQ (may issue), WAIT (1 outstanding, keep), KILL (1 outstanding, discard).
//  imem_req_o = (state==REQ) & pc_en_i & ~skid_valid & ~branch_taken_i; combinational.
//  REQ: req&gnt -> req_pc_q<=pc_q, pc_q<=pc_q+4 (mod 2^32, 0xFFFFFFFC wraps to 0), ->WAIT. No gnt -> stay, addr stable.
//  WAIT, rvalid, no branch: IF_ID_en_i=1 & skid empty -> IF/ID<={rdata,req_pc_q,1}; else -> skid<=response. ->REQ.
//  Skid valid & IF_ID_en_i=1 & no branch: IF/ID<=skid, skid cleared (skid has priority; rvalid cannot coincide).
//  IF_ID_en_i=1, no branch, nothing available: IF/ID<={NOP_INST,pc_ID_o,0} (bubble).
//  IF_ID_en_i=0, no branch: IF/ID holds all three outputs unchanged.
//  branch_taken_i=1 (priority over all stalls): IF/ID<={NOP_INST,0,0}; skid cleared; pc_q<={target[31:2],2'b00};
//   state: WAIT w/o rvalid -> KILL; WAIT with rvalid same cycle -> REQ (response dropped); REQ/KILL unchanged.
//  KILL: rvalid -> response dropped, ->REQ; further branch in KILL only updates pc_q.
//  Fetch latency: grant at cycle N, rvalid at N+1 -> valid in IF/ID from N+2 when unstalled.
//  Steady state with 1-cycle memory: one instruction per 2 cycles (single outstanding); no duplicates, no loss.
//  Reset mid-transaction: outstanding response after reset is ignored (state REQ, rvalid not expected); memory is reset together.
// TESTING
//  Reset, 1-cycle imem (gnt=1, rvalid next cycle) -> addrs 0x0,0x4,0x8..., IF/ID pc 0x0,0x4 valid=1, no gaps beyond protocol.
//  Load-use stall: pc_en_i=IF_ID_en_i=0 for 1 cycle while rvalid returns 0x401284B3 -> skid holds it; released next cycle, order kept.
//  branch_taken_i with target 0x0000_0102 while WAIT -> next addr 0x100, late rvalid dropped, IF/ID NOP valid=0.
//  branch_taken_i same cycle as rvalid and IF_ID_en_i=0 -> response dropped, IF/ID NOP, no skid entry.
//  gnt held low 3 cycles at pc 0x20 -> imem_addr_o stable 0x20, IF/ID bubbles valid=0, pc_q unchanged.
//  pc_q=0xFFFF_FFFC granted -> next imem_addr_o=0x0000_0000; rst_i asserted in WAIT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
// One request may be outstanding at a time; the response arrives at least one cycle after grant.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// IF stage of the RV32I pipeline: fetch PC, single-outstanding imem port, 1-entry skid buffer
// for responses returning during a decode stall, and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          pc_en_i,
  input  logic          IF_ID_en_i,
  input  logic          branch_taken_i,
  input  logic [31:0]   branch_target_i,
  fetch_stage_if.master imem,
  output logic [31:0]   inst_ID_o,
  output logic [31:0]   pc_ID_o,
  output logic          valid_ID_o
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_KILL = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] inst_id_q, inst_id_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic        valid_id_q, valid_id_d;

  logic req;
  logic rsp_fire;

  assign req       = (state_q == ST_REQ) & pc_en_i & ~skid_valid_q & ~branch_taken_i;
  assign rsp_fire  = (state_q == ST_WAIT) & imem.rvalid;
  assign imem.req  = req;
  assign imem.addr = pc_q;

  assign inst_ID_o  = inst_id_q;
  assign pc_ID_o    = pc_id_q;
  assign valid_ID_o = valid_id_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    inst_id_d    = inst_id_q;
    pc_id_d      = pc_id_q;
    valid_id_d   = valid_id_q;

    if (branch_taken_i) begin
      // A redirect beats every stall; an in-flight response becomes stale and must be discarded.
      pc_d         = branch_target_i & 32'hFFFF_FFFC;
      inst_id_d    = NOP_INST;
      pc_id_d      = 32'h0000_0000;
      valid_id_d   = 1'b0;
      skid_valid_d = 1'b0;
      if (state_q == ST_WAIT) begin
        state_d = imem.rvalid ? ST_REQ : ST_KILL;
      end
    end else begin
      case (state_q)
        ST_REQ: begin
          if (req && imem.gnt) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem.rvalid) begin
            state_d = ST_REQ;
          end
        end
        ST_KILL: begin
          if (imem.rvalid) begin
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase

      if (IF_ID_en_i) begin
        if (skid_valid_q) begin
          inst_id_d    = skid_inst_q;
          pc_id_d      = skid_pc_q;
          valid_id_d   = 1'b1;
          skid_valid_d = 1'b0;
        end else if (rsp_fire) begin
          inst_id_d  = imem.rdata;
          pc_id_d    = req_pc_q;
          valid_id_d = 1'b1;
        end else begin
          inst_id_d  = NOP_INST;
          valid_id_d = 1'b0;
        end
      end

      // Decode is stalled (or the skid is draining) so park the response for later.
      if (rsp_fire && (!IF_ID_en_i || skid_valid_q)) begin
        skid_valid_d = 1'b1;
        skid_inst_d  = imem.rdata;
        skid_pc_d    = req_pc_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= 32'h0000_0000;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= NOP_INST;
      skid_pc_q    <= 32'h0000_0000;
      inst_id_q    <= NOP_INST;
      pc_id_q      <= 32'h0000_0000;
      valid_id_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      inst_id_q    <= inst_id_d;
      pc_id_q      <= pc_id_d;
      valid_id_q   <= valid_id_d;
    end
  end

endmodule
